// File: rtl/vga_timing_gen.sv
// VGA timing generator with two parameter-table modes; mode switches take effect only at frame wrap.
// Every output is registered from the same next-state position, so all outputs describe one (hcount,vcount).
module vga_timing_gen #(
  parameter int CNT_W = 11,
  parameter logic [4*CNT_W-1:0] H_TIM_0 = {CNT_W'(1024), CNT_W'(1048), CNT_W'(1184), CNT_W'(1344)},
  parameter logic [4*CNT_W-1:0] V_TIM_0 = {CNT_W'(768), CNT_W'(771), CNT_W'(777), CNT_W'(806)},
  parameter logic [4*CNT_W-1:0] H_TIM_1 = {CNT_W'(800), CNT_W'(840), CNT_W'(968), CNT_W'(1056)},
  parameter logic [4*CNT_W-1:0] V_TIM_1 = {CNT_W'(600), CNT_W'(601), CNT_W'(605), CNT_W'(628)},
  parameter logic HSYNC_POL = 1'b1,
  parameter logic VSYNC_POL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode_sel,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             hblnk,
  output logic             vblnk,
  output logic             frame_start,
  output logic             line_start,
  output logic             mode_active
);

  localparam int unsigned TOT = 0;
  localparam int unsigned SE  = 1;
  localparam int unsigned SS  = 2;
  localparam int unsigned ACT = 3;

  typedef enum logic {MODE0 = 1'b0, MODE1 = 1'b1} mode_t;

  function automatic logic [CNT_W-1:0] fld(input logic [4*CNT_W-1:0] t, input int unsigned k);
    return t[k*CNT_W +: CNT_W];
  endfunction

  function automatic bit tim_ok(input logic [4*CNT_W-1:0] t);
    longint act, ss, se, tot;
    act = longint'(fld(t, ACT));
    ss  = longint'(fld(t, SS));
    se  = longint'(fld(t, SE));
    tot = longint'(fld(t, TOT));
    return (act <= ss) && (ss < se) && (se <= tot) && (tot <= (longint'(1) << CNT_W));
  endfunction

  function automatic logic pol_lvl(input logic act, input logic pol);
    return pol ? act : ~act;
  endfunction

  if (!tim_ok(H_TIM_0) || !tim_ok(V_TIM_0) || !tim_ok(H_TIM_1) || !tim_ok(V_TIM_1)) begin : g_bad_timing
    $error("vga_timing_gen: timing table must satisfy ACTIVE <= SYNC_START < SYNC_END <= TOTAL <= 2**CNT_W");
  end

  mode_t                mode_q;
  mode_t                mode_nxt;
  logic [4*CNT_W-1:0]   h_tim, v_tim, h_tim_nxt, v_tim_nxt;
  logic                 h_wrap, v_wrap, f_wrap;
  logic [CNT_W-1:0]     h_nxt, v_nxt;

  // Current-mode tables decide the wrap; next-mode tables decode the position being entered.
  assign h_tim     = (mode_q == MODE1) ? H_TIM_1 : H_TIM_0;
  assign v_tim     = (mode_q == MODE1) ? V_TIM_1 : V_TIM_0;
  assign h_wrap    = (hcount == fld(h_tim, TOT) - CNT_W'(1));
  assign v_wrap    = (vcount == fld(v_tim, TOT) - CNT_W'(1));
  assign f_wrap    = h_wrap && v_wrap;
  assign h_nxt     = h_wrap ? '0 : hcount + CNT_W'(1);
  assign v_nxt     = !h_wrap ? vcount : (v_wrap ? '0 : vcount + CNT_W'(1));
  assign mode_nxt  = f_wrap ? mode_t'(mode_sel) : mode_q;
  assign h_tim_nxt = (mode_nxt == MODE1) ? H_TIM_1 : H_TIM_0;
  assign v_tim_nxt = (mode_nxt == MODE1) ? V_TIM_1 : V_TIM_0;

  assign mode_active = (mode_q == MODE1);

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= mode_t'(mode_sel);
      hcount      <= '0;
      vcount      <= '0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else if (en) begin
      mode_q      <= mode_nxt;
      hcount      <= h_nxt;
      vcount      <= v_nxt;
      hsync       <= pol_lvl((h_nxt >= fld(h_tim_nxt, SS)) && (h_nxt < fld(h_tim_nxt, SE)), HSYNC_POL);
      vsync       <= pol_lvl((v_nxt >= fld(v_tim_nxt, SS)) && (v_nxt < fld(v_tim_nxt, SE)), VSYNC_POL);
      hblnk       <= (h_nxt >= fld(h_tim_nxt, ACT));
      vblnk       <= (v_nxt >= fld(v_tim_nxt, ACT));
      frame_start <= f_wrap;
      line_start  <= h_wrap;
    end
  end

endmodule
